bcd_scan_decoder: RTL
=====================

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 The module SHALL take parameter DIGITS, default 4, meaning the number of BCD digits scanned, legal range 1..8.
REQ-002 The module SHALL take parameter DWELL, default 1000, meaning the clock cycles each digit stays selected, legal minimum 1.
REQ-003 The module SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port inp, input, 4*DIGITS bits: packed BCD value; digit k is inp[4k+3:4k], and digit 0 is least significant.
REQ-007 Port load, input, 1 bit: strobe that captures inp.
REQ-008 Port err_clr, input, 1 bit: clears the sticky error flag.
REQ-009 Port out, output, 10 bits: one-hot decimal decode of the displayed digit; bit n is set for value n.
REQ-010 Port seg, output, 7 bits: active-high segments {g,f,e,d,c,b,a} of the displayed digit.
REQ-011 Port dig, output, DIGITS bits: one-hot select of the displayed digit.
REQ-012 Port pending, output, 1 bit: a loaded value is waiting for the frame boundary.
REQ-013 Port err, output, 1 bit: sticky flag for an invalid BCD nibble.

Function
REQ-014 Dwell counter cnt SHALL count 0..DWELL-1 and wrap; digit index idx SHALL advance by 1 on the cycle cnt=DWELL-1.
REQ-015 idx SHALL wrap from DIGITS-1 to 0; the cycle with cnt=DWELL-1 and idx=DIGITS-1 is the frame boundary.
REQ-016 load=1 SHALL write inp into the shadow register and set pending=1; a later load before the boundary overwrites the shadow (last wins).
REQ-017 At the frame boundary with pending=1, shadow SHALL copy to the active register and pending SHALL clear.
REQ-018 load=1 on the boundary cycle SHALL write inp directly into the active register and leave pending=0.
REQ-019 The active register SHALL never change except at a frame boundary, so no frame shows mixed old and new values.
REQ-020 out, seg and dig SHALL be registered, reflecting idx and the active register of the previous cycle (1-cycle latency).
REQ-021 Decoding of nibbles 0..9 SHALL be standard: out=1<<n; seg values are 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-022 A displayed nibble of 10..15 SHALL drive out=0 and seg=0 while dig stays asserted, and SHALL set err=1.
REQ-023 err SHALL stay set until err_clr=1; if err_clr and a new invalid nibble occur in the same cycle, err SHALL remain 1.
REQ-024 DWELL=1 SHALL advance idx every cycle; DIGITS=1 SHALL hold dig=1 permanently, with every DWELL-th cycle a boundary.

Reset
REQ-025 rst_n=0 at a clock edge SHALL clear cnt, idx, shadow, active, pending and err, and drive out=0, seg=0, dig=0.
REQ-026 The first cycle after rst_n returns high SHALL show digit 0 of value 0: out=10'h001, seg=7'h3F, dig=1.
REQ-027 Reset asserted mid-frame or while pending=1 SHALL discard the pending value; load is ignored while rst_n=0.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL blank zero digits above the most significant nonzero digit: dig bit, out and seg all 0 for those digit slots.
REQ-029 Under LEADING_ZERO_BLANK_EN, digit 0 SHALL never be blanked and scan timing SHALL be unchanged.
REQ-030 Without LEADING_ZERO_BLANK_EN, every digit SHALL be displayed, including zeros.

Verification (DIGITS=4, DWELL=4)
REQ-031 Reset: rst_n=0 for 2 cycles, then 1 -> out=0, seg=0, dig=0 during reset, then out=10'h001, seg=7'h3F, dig=4'b0001.
REQ-032 Scan: idle after reset -> dig sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
REQ-033 Load mid-frame: load inp=16'h1234 at idx=1 -> pending=1 and display stays 0 until the boundary; then digit 0 shows out=10'h010, seg=7'h66 and pending=0.
REQ-034 Last wins: load 16'h1111 then 16'h2222 within one frame -> the next frame shows 2 on all digits (seg=7'h5B).
REQ-035 Invalid: load 16'h00A0 -> on digit 1, out=0, seg=0, err=1; err stays 1 after the frame until err_clr=1.
REQ-036 Blanking: load 16'h0042 -> with the macro, digits 3 and 2 give dig=0, out=0, seg=0; without it they give seg=7'h3F.

Source files
------------

// File: rtl/bcd_scan_decoder.sv
// Multiplexed BCD display scanner with frame-synchronous value update and registered decode.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank zero digits above the most significant nonzero digit).
module bcd_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   inp,
    input  logic                  load,
    input  logic                  err_clr,
    output logic [9:0]            out,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  pending,
    output logic                  err
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   shadow_q, shadow_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic                  pending_q, pending_d;
    logic                  err_q, err_d;
    logic [9:0]            out_q, out_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_q, dig_d;

    logic                  cnt_wrap;
    logic                  boundary;
    logic [3:0]            nib;
    logic                  blank;
    logic                  nib_bad;

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        boundary = cnt_wrap && (idx_q == IDX_LAST);

        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // The active register only changes on the frame boundary; a load there bypasses the shadow.
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load && boundary) begin
            active_d  = inp;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = inp;
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        nib = 4'(active_q >> {idx_q, 2'b00});
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif

        case (nib)
            4'd0:    seg_d = 7'h3F;
            4'd1:    seg_d = 7'h06;
            4'd2:    seg_d = 7'h5B;
            4'd3:    seg_d = 7'h4F;
            4'd4:    seg_d = 7'h66;
            4'd5:    seg_d = 7'h6D;
            4'd6:    seg_d = 7'h7D;
            4'd7:    seg_d = 7'h07;
            4'd8:    seg_d = 7'h7F;
            4'd9:    seg_d = 7'h6F;
            default: seg_d = '0;
        endcase
        nib_bad = (nib > 4'd9);
        out_d   = nib_bad ? '0 : (10'd1 << nib);
        dig_d   = DIGITS'(1) << idx_q;

        if (blank) begin
            out_d   = '0;
            seg_d   = '0;
            dig_d   = '0;
            nib_bad = 1'b0;
        end

        err_d = (err_q && !err_clr) || nib_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= '0;
            seg_q     <= '0;
            dig_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            out_q     <= out_d;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
        end
    end

    assign out     = out_q;
    assign seg     = seg_q;
    assign dig     = dig_q;
    assign pending = pending_q;
    assign err     = err_q;

endmodule
